// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: opcodes, ALU codes, immediate selectors and decoded control word for the decode stage
package rv_decode_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
    ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_ctrl_e;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_U} imm_sel_e;
  typedef struct packed {
    alu_ctrl_e alu;
    logic      use_imm;
    logic      uses_rs2;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      illegal;
    logic      zero_a;
  } ctrl_t;
  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational opcode/funct decode into a control word plus sign-extended immediate
//   instr_i  instruction word
//   ctrl_o   decoded control word
//   imm_o    I/S/U immediate, sign-extended to W
module decode_ctrl
  import rv_decode_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [31:0]  instr_i,
  output ctrl_t        ctrl_o,
  output logic [W-1:0] imm_o
);
  imm_sel_e          sel;
  logic signed [31:0] imm32;
  always_comb begin
    ctrl_o = '{alu: ALU_ADD, default: 1'b0};
    sel = IMM_I;
    case (instr_i[6:0])
      OP_R: begin
        ctrl_o.alu = alu_op(instr_i[14:12], instr_i[30]);
        ctrl_o.uses_rs2 = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_I: begin
        // bit30 is immediate data except for the right-shift pair
        ctrl_o.alu = alu_op(instr_i[14:12], instr_i[30] & (instr_i[14:12] == 3'b101));
        ctrl_o.use_imm = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.use_imm = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      OP_STORE: begin
        sel = IMM_S;
        ctrl_o.use_imm = 1'b1;
        ctrl_o.uses_rs2 = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_LUI: begin
        sel = IMM_U;
        ctrl_o.alu = ALU_PASSB;
        ctrl_o.use_imm = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.zero_a = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    imm32 = sel == IMM_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
            sel == IMM_U ? {instr_i[31:12], 12'b0} : {{20{instr_i[31]}}, instr_i[31:20]};
    imm_o = W'(imm32);
  end
endmodule

// File: rtl/register_file.sv
// register_file: N x W register file, async-clear, two combinational read ports, x0 never written
//   we_i/waddr_i/wdata_i  write port (ignored for address 0)
//   raddrN_i/rdataN_o     read ports, no internal forwarding
module register_file #(
  parameter int W = 32,
  parameter int N = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [W-1:0]  rdata1_o,
  output logic [W-1:0]  rdata2_o
);
  logic [W-1:0] mem_q [N];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int k = 0; k < N; k++) mem_q[k] <= '0;
    else if (we_i && waddr_i != '0) mem_q[waddr_i] <= wdata_i;
  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: handshaked RV32I decode stage with bypassed register read and ID/EX register
//   in_valid/in_ready/instruction/pc_in   upstream beat from fetch
//   flush                                 drop ID/EX contents and the current input beat
//   wb_en/wb_rd/wb_data                   register write-back (optionally forwarded to reads)
//   out_valid/out_ready + *_out           ID/EX op towards execute, held while stalled downstream
module decode_stage_pipe
  import rv_decode_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTRUCTION = 32,
  parameter int ALU_CONTROL = 4,
  parameter int REG_COUNT   = 32,
  parameter int WB_BYPASS   = 1,
  localparam int RA_W = $clog2(REG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTRUCTION-1:0] instruction,
  input  logic [DATA_WIDTH-1:0]  pc_in,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [RA_W-1:0]        wb_rd,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALU_CONTROL-1:0] alu_control,
  output logic [DATA_WIDTH-1:0]  opa_out,
  output logic [DATA_WIDTH-1:0]  opb_out,
  output logic [DATA_WIDTH-1:0]  rs2_data_out,
  output logic [RA_W-1:0]        rd_out,
  output logic                   reg_write_out,
  output logic                   mem_read_out,
  output logic                   mem_write_out,
  output logic                   illegal_out,
  output logic [DATA_WIDTH-1:0]  pc_out
);
  typedef struct packed {
    logic [ALU_CONTROL-1:0] alu;
    logic [DATA_WIDTH-1:0]  opa;
    logic [DATA_WIDTH-1:0]  opb;
    logic [DATA_WIDTH-1:0]  rs2d;
    logic [DATA_WIDTH-1:0]  pc;
    logic [RA_W-1:0]        rd;
    logic                   rw;
    logic                   mr;
    logic                   mw;
    logic                   ill;
  } idex_t;
  ctrl_t                 ctrl;
  logic [DATA_WIDTH-1:0] imm, rf1, rf2, rs1_v, rs2_v;
  logic [RA_W-1:0]       rs1, rs2, rd;
  logic                  stall, accept, out_valid_q, out_valid_d;
  idex_t                 idex_q, idex_d;
  assign rs1 = instruction[15 +: RA_W];
  assign rs2 = instruction[20 +: RA_W];
  assign rd  = instruction[7 +: RA_W];
  decode_ctrl #(.W(DATA_WIDTH)) u_dec (
    .instr_i (instruction[31:0]),
    .ctrl_o  (ctrl),
    .imm_o   (imm)
  );
  register_file #(.W(DATA_WIDTH), .N(REG_COUNT)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rf1),
    .rdata2_o (rf2)
  );
  always_comb begin
    // x0 check first so a write-back aimed at x0 is never forwarded
    rs1_v = rs1 == '0 ? '0 : (WB_BYPASS != 0 && wb_en && wb_rd == rs1) ? wb_data : rf1;
    rs2_v = rs2 == '0 ? '0 : (WB_BYPASS != 0 && wb_en && wb_rd == rs2) ? wb_data : rf2;
    stall = out_valid_q & idex_q.mr & (idex_q.rd != '0) &
            ((idex_q.rd == rs1) | ((idex_q.rd == rs2) & ctrl.uses_rs2));
    // flush always swallows the input beat, even under stall or backpressure
    in_ready = flush | ((!out_valid_q | out_ready) & !stall);
    accept = in_valid & in_ready & !flush;
    out_valid_d = !flush & (accept | (out_valid_q & !out_ready));
    idex_d = accept ? idex_t'{
      alu:  ALU_CONTROL'(ctrl.alu),
      opa:  ctrl.zero_a ? '0 : rs1_v,
      opb:  ctrl.use_imm ? imm : rs2_v,
      rs2d: rs2_v,
      pc:   pc_in,
      rd:   rd,
      rw:   ctrl.reg_write & (rd != '0),
      mr:   ctrl.mem_read,
      mw:   ctrl.mem_write,
      ill:  ctrl.illegal
    } : idex_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid_q <= 1'b0;
      idex_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      idex_q <= idex_d;
    end
  assign out_valid     = out_valid_q;
  assign alu_control   = idex_q.alu;
  assign opa_out       = idex_q.opa;
  assign opb_out       = idex_q.opb;
  assign rs2_data_out  = idex_q.rs2d;
  assign rd_out        = idex_q.rd;
  assign reg_write_out = idex_q.rw;
  assign mem_read_out  = idex_q.mr;
  assign mem_write_out = idex_q.mw;
  assign illegal_out   = idex_q.ill;
  assign pc_out        = idex_q.pc;
endmodule
